writeback_unit: RTL and testbench

- Writer side of the general purpose register file: owns the single write port (write_enable, write_address, write_data).
- Merges two result sources:
  - the in-order MEM/WB pipeline result;
  - late results from multicycle units (mult/div), which arrive over a valid/ready handshake and are buffered in a small FIFO.
- Register file reads are combinational and writes land on the rising edge, so a same-cycle read of a register being written would return the stale value. This block provides same-cycle bypass data for both read ports.
- It also flags reads of registers with queued late results so the hazard unit can stall decode.

---
 rtl/writeback_unit_pkg.sv | 16 +
 rtl/writeback_unit_if.sv | 42 ++++
 rtl/writeback_unit_late_result_fifo.sv | 51 +++++
 rtl/writeback_unit.sv | 57 +++++
 tb/tb_writeback_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared widths, zero-register constant and record layouts for the writeback unit.
package writeback_unit_pkg;
  localparam int REGISTER_SIZE = 31;
  localparam int ADDRESS_SIZE = $clog2(REGISTER_SIZE + 1);
  localparam logic [ADDRESS_SIZE-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] address;
    logic [REGISTER_SIZE:0] data;
  } late_result_t;
  typedef struct packed {
    logic valid;
    logic write_enable;
    logic [ADDRESS_SIZE-1:0] address;
    logic [REGISTER_SIZE:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: pipeline, late-result, register-file write and decode bypass signals of the writeback unit.
interface writeback_unit_if;
  import writeback_unit_pkg::*;
  logic mem_valid;
  logic mem_write_enable;
  logic [ADDRESS_SIZE-1:0] mem_write_address;
  logic [REGISTER_SIZE:0] mem_write_data;
  logic pipeline_stall;
  logic pipeline_flush;
  logic late_valid;
  logic [ADDRESS_SIZE-1:0] late_address;
  logic [REGISTER_SIZE:0] late_data;
  logic late_ready;
  logic write_enable;
  logic [ADDRESS_SIZE-1:0] write_address;
  logic [REGISTER_SIZE:0] write_data;
  logic [ADDRESS_SIZE-1:0] read_address_1;
  logic [ADDRESS_SIZE-1:0] read_address_2;
  logic bypass_hit_1;
  logic bypass_hit_2;
  logic [REGISTER_SIZE:0] bypass_data_1;
  logic [REGISTER_SIZE:0] bypass_data_2;
  logic pending_hit_1;
  logic pending_hit_2;
  logic stall_request;
  modport slave (
    input mem_valid, mem_write_enable, mem_write_address, mem_write_data,
    input pipeline_stall, pipeline_flush, late_valid, late_address, late_data,
    input read_address_1, read_address_2,
    output late_ready, write_enable, write_address, write_data,
    output bypass_hit_1, bypass_hit_2, bypass_data_1, bypass_data_2,
    output pending_hit_1, pending_hit_2, stall_request
  );
  modport master (
    output mem_valid, mem_write_enable, mem_write_address, mem_write_data,
    output pipeline_stall, pipeline_flush, late_valid, late_address, late_data,
    output read_address_1, read_address_2,
    input late_ready, write_enable, write_address, write_data,
    input bypass_hit_1, bypass_hit_2, bypass_data_1, bypass_data_2,
    input pending_hit_1, pending_hit_2, stall_request
  );
endinterface

// File: rtl/writeback_unit_late_result_fifo.sv
// late_result_fifo: small circular buffer of late results exposing every slot's address for the pending compare.
module late_result_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  late_result_t push_entry,
  output late_result_t head,
  output logic full,
  output logic empty,
  output logic [ADDRESS_SIZE-1:0] entry_address [DEPTH],
  output logic [DEPTH-1:0] entry_live
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  late_result_t mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return int'(p) == DEPTH - 1 ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    rd_d = pop ? wrap_inc(rd_q) : rd_q;
    wr_d = push ? wrap_inc(wr_q) : wr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    full = int'(cnt_q) == DEPTH;
    empty = cnt_q == '0;
    head = mem_q[rd_q];
    // a slot is live when it sits inside the occupied window and is not the head leaving this cycle
    for (int i = 0; i < DEPTH; i++) begin
      entry_address[i] = mem_q[i].address;
      entry_live[i] = (((i + DEPTH - int'(rd_q)) % DEPTH) < int'(cnt_q)) && !(pop && i == int'(rd_q));
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= push_entry;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates the single register-file write port between the WB register and queued late results,
// and provides same-cycle bypass and pending-result hazard flags to decode.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input logic system_clock,
  input logic reset,
  writeback_unit_if.slave wb
);
  wb_entry_t wb_q, wb_d;
  late_result_t head, push_entry;
  logic full, empty, push, pop, hold, wb_wants, fifo_wins, we;
  logic [ADDRESS_SIZE-1:0] wa;
  logic [REGISTER_SIZE:0] wd;
  logic [ADDRESS_SIZE-1:0] entry_address [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] entry_live;
  late_result_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(system_clock), .rst(reset), .push(push), .pop(pop), .push_entry(push_entry),
    .head(head), .full(full), .empty(empty), .entry_address(entry_address), .entry_live(entry_live)
  );
  always_comb begin
    wb_wants = wb_q.valid & wb_q.write_enable & (wb_q.address != ZERO_REG);
    // a full queue must drain first, otherwise the pipeline result has priority
    fifo_wins = !empty & (full | !wb_wants);
    pop = fifo_wins;
    wb.stall_request = full & wb_wants;
    wb.late_ready = !full | pop;
    push = wb.late_valid & wb.late_ready;
    push_entry = '{address: wb.late_address, data: wb.late_data};
    we = fifo_wins ? head.address != ZERO_REG : wb_wants;
    wa = !we ? ZERO_REG : fifo_wins ? head.address : wb_q.address;
    wd = !we ? '0 : fifo_wins ? head.data : wb_q.data;
    wb.write_enable = we;
    wb.write_address = wa;
    wb.write_data = wd;
    hold = wb.pipeline_stall | wb.stall_request;
    wb_d = hold ? wb_q : '{valid: wb.mem_valid & !wb.pipeline_flush, write_enable: wb.mem_write_enable,
                           address: wb.mem_write_address, data: wb.mem_write_data};
  end
  always_comb begin
    wb.bypass_hit_1 = we & (wb.read_address_1 == wa) & (wb.read_address_1 != ZERO_REG);
    wb.bypass_hit_2 = we & (wb.read_address_2 == wa) & (wb.read_address_2 != ZERO_REG);
    wb.bypass_data_1 = wd;
    wb.bypass_data_2 = wd;
    wb.pending_hit_1 = 1'b0;
    wb.pending_hit_2 = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      wb.pending_hit_1 |= entry_live[i] & (entry_address[i] == wb.read_address_1) & (wb.read_address_1 != ZERO_REG);
      wb.pending_hit_2 |= entry_live[i] & (entry_address[i] == wb.read_address_2) & (wb.read_address_2 != ZERO_REG);
    end
  end
  always_ff @(posedge system_clock or posedge reset)
    if (reset) wb_q <= '0;
    else wb_q <= wb_d;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and random stimulus checked against a queue-based model of the writeback rules.
module tb_writeback_unit;
  import writeback_unit_pkg::*;
  localparam int QD = 2;
  typedef struct {
    logic [ADDRESS_SIZE-1:0] a;
    logic [REGISTER_SIZE:0] d;
  } res_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  writeback_unit_if bus();
  writeback_unit #(.QUEUE_DEPTH(QD)) dut (.system_clock(clk), .reset(rst), .wb(bus));
  res_t lq[$];
  logic m_wv, m_we;
  logic [ADDRESS_SIZE-1:0] m_wa;
  logic [REGISTER_SIZE:0] m_wd;
  bit e_pop, e_push, e_stall;
  int checks = 0, failures = 0, pushes = 0, writes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    lq.delete();
    m_wv = 0; m_we = 0; m_wa = '0; m_wd = '0;
  endtask

  task automatic set_mem(input bit v, input bit we, input int a, input logic [31:0] d);
    bus.mem_valid = v; bus.mem_write_enable = we; bus.mem_write_address = a[4:0]; bus.mem_write_data = d;
  endtask

  task automatic set_late(input bit v, input int a, input logic [31:0] d);
    bus.late_valid = v; bus.late_address = a[4:0]; bus.late_data = d;
  endtask

  task automatic set_rd(input int r1, input int r2);
    bus.read_address_1 = r1[4:0]; bus.read_address_2 = r2[4:0];
  endtask

  // compute what the rules demand for the current inputs and compare every output
  task automatic settle();
    bit wants, full, lw, ewe, p1, p2;
    logic [ADDRESS_SIZE-1:0] ea;
    logic [REGISTER_SIZE:0] ed;
    #1;
    wants = m_wv && m_we && m_wa != 0;
    full = lq.size() == QD;
    lw = lq.size() > 0 && (full || !wants);
    ewe = lw ? lq[0].a != 0 : wants;
    ea = !ewe ? '0 : lw ? lq[0].a : m_wa;
    ed = !ewe ? '0 : lw ? lq[0].d : m_wd;
    e_stall = full && wants;
    e_pop = lw;
    e_push = bus.late_valid && (!full || lw);
    p1 = 0; p2 = 0;
    for (int i = lw ? 1 : 0; i < lq.size(); i++) begin
      if (lq[i].a == bus.read_address_1 && bus.read_address_1 != 0) p1 = 1;
      if (lq[i].a == bus.read_address_2 && bus.read_address_2 != 0) p2 = 1;
    end
    if (e_push) pushes++;
    if (bus.write_enable && bus.write_address >= 11) writes++;
    chk("write_enable", 32'(bus.write_enable), 32'(ewe));
    chk("write_address", 32'(bus.write_address), 32'(ea));
    chk("write_data", bus.write_data, ed);
    chk("late_ready", 32'(bus.late_ready), 32'(!full || lw));
    chk("stall_request", 32'(bus.stall_request), 32'(e_stall));
    chk("bypass_hit_1", 32'(bus.bypass_hit_1), 32'(ewe && bus.read_address_1 == ea && ea != 0));
    chk("bypass_hit_2", 32'(bus.bypass_hit_2), 32'(ewe && bus.read_address_2 == ea && ea != 0));
    chk("bypass_data_1", bus.bypass_data_1, ed);
    chk("bypass_data_2", bus.bypass_data_2, ed);
    chk("pending_hit_1", 32'(bus.pending_hit_1), 32'(p1));
    chk("pending_hit_2", 32'(bus.pending_hit_2), 32'(p2));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) clear_model();
    else begin
      if (e_pop) void'(lq.pop_front());
      if (e_push) lq.push_back('{a: bus.late_address, d: bus.late_data});
      if (!(bus.pipeline_stall || e_stall)) begin
        m_wv = bus.mem_valid && !bus.pipeline_flush;
        m_we = bus.mem_write_enable; m_wa = bus.mem_write_address; m_wd = bus.mem_write_data;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    rst = 1;
    set_mem(0, 0, 0, 0); set_late(0, 0, 0); set_rd(0, 0);
    bus.pipeline_stall = 0; bus.pipeline_flush = 0;
    clear_model();
    @(negedge clk);
    step();
    rst = 0;
    step();
    // pipeline write with bypass
    set_mem(1, 1, 5, 32'hDEADBEEF); set_rd(5, 6);
    step();
    set_mem(0, 0, 0, 0);
    settle();
    chk("pipe_we", 32'(bus.write_enable), 1);
    chk("pipe_addr", 32'(bus.write_address), 5);
    chk("pipe_bypass", 32'(bus.bypass_hit_1), 1);
    chk("pipe_bypass_data", bus.bypass_data_1, 32'hDEADBEEF);
    advance();
    // register zero from both sources
    set_mem(1, 1, 0, 32'h1111); set_late(1, 0, 32'h2222); set_rd(0, 0);
    step();
    set_mem(0, 0, 0, 0); set_late(0, 0, 0);
    settle();
    chk("r0_we", 32'(bus.write_enable), 0);
    chk("r0_bypass", 32'(bus.bypass_hit_1), 0);
    advance();
    step();
    // flush kills the entering instruction
    set_mem(1, 1, 6, 32'h66); bus.pipeline_flush = 1;
    step();
    set_mem(0, 0, 0, 0); bus.pipeline_flush = 0;
    settle();
    chk("flush_we", 32'(bus.write_enable), 0);
    advance();
    // late result drains while WB idle
    set_late(1, 7, 32'h1234); set_rd(7, 0);
    step();
    set_late(0, 0, 0);
    settle();
    chk("late_we", 32'(bus.write_enable), 1);
    chk("late_addr", 32'(bus.write_address), 7);
    chk("late_data", bus.write_data, 32'h1234);
    advance();
    // late result waits behind a busy WB and reports pending
    set_mem(1, 1, 4, 32'h44);
    step();
    set_late(1, 7, 32'h77);
    step();
    set_late(0, 0, 0); set_mem(0, 0, 0, 0);
    settle();
    chk("pending_7", 32'(bus.pending_hit_1), 1);
    advance();
    step();
    settle();
    chk("pending_7_clear", 32'(bus.pending_hit_1), 0);
    advance();
    // full queue preempts a WB write to r3
    set_mem(1, 1, 3, 32'h33); set_rd(3, 9);
    step();
    set_late(1, 9, 32'hAA);
    step();
    set_late(1, 10, 32'hBB);
    step();
    set_late(0, 0, 0); set_mem(0, 0, 0, 0);
    settle();
    chk("full_stall", 32'(bus.stall_request), 1);
    chk("full_addr", 32'(bus.write_address), 9);
    chk("full_data", bus.write_data, 32'hAA);
    advance();
    settle();
    chk("held_addr", 32'(bus.write_address), 3);
    chk("held_ready", 32'(bus.late_ready), 1);
    advance();
    step();
    step();
    // streaming through a full queue: push and pop on the same edge
    pushes = 0; writes = 0;
    set_mem(1, 1, 3, 32'h3);
    for (int k = 0; k < 12; k++) begin
      if (k == 3) set_mem(0, 0, 0, 0);
      set_late(1, 11 + k, 32'h100 + k);
      step();
    end
    set_late(0, 0, 0);
    for (int k = 0; k < 4; k++) step();
    chk("stream_count", 32'(writes), 32'(pushes));
    // reset in the middle of operation with two entries queued
    set_mem(1, 1, 2, 32'h22);
    step();
    set_late(1, 12, 32'hC);
    step();
    set_late(1, 13, 32'hD);
    step();
    set_late(0, 0, 0);
    rst = 1;
    #1;
    chk("rst_we", 32'(bus.write_enable), 0);
    chk("rst_ready", 32'(bus.late_ready), 1);
    clear_model();
    step();
    set_mem(0, 0, 0, 0);
    rst = 0;
    for (int k = 0; k < 3; k++) step();
    // random traffic
    for (int k = 0; k < 400; k++) begin
      set_mem($urandom % 2, $urandom % 4 != 0, $urandom_range(0, 7), $urandom);
      set_late($urandom % 3 == 0, $urandom_range(0, 7), $urandom);
      set_rd($urandom_range(0, 7), $urandom_range(0, 7));
      bus.pipeline_stall = $urandom % 8 == 0;
      bus.pipeline_flush = $urandom % 8 == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
